// File: rtl/decoder_pkg.sv
// ============================================================================
// Module      : decoder_pkg
// Description : Shared FSM state encoding and hold/gap counter width for the
//               one-hot decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_pkg;

  localparam int CNT_W = 4;

  // ST_ prefix keeps the literals clear of the decoder's GAP parameter.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/hold_counter.sv
// ============================================================================
// Module      : hold_counter
// Description : Loadable down-counter that saturates at zero; done_o flags
//               the final cycle of a timed interval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hold_counter
  import decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/onehot_decoder.sv
// ============================================================================
// Module      : onehot_decoder
// Description : Accepts binary codes through a one-entry pending buffer and
//               drives each as a registered one-hot pattern for HOLD cycles,
//               separated by GAP all-zero cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_decoder
  import decoder_pkg::*;
#(
  parameter int N    = 3,
  parameter int HOLD = 2,
  parameter int GAP  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            in_valid,
  input  logic [N-1:0]    in_code,
  output logic            in_ready,
  output logic [2**N-1:0] decode,
  output logic            out_valid,
  output logic            busy
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP - 1);
  localparam bit               HAS_GAP = (GAP > 0);

  state_t            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [N-1:0]      pend_code_q, pend_code_d;
  logic [N-1:0]      code_q, code_d;
  logic [2**N-1:0]   decode_q, decode_d;
  logic              out_valid_q;
  logic              busy_q, busy_d;
  logic              run_q;

  logic              xfer;
  logic              decide;
  logic              bypass;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_done;

  // run_q holds in_ready low until the first clock edge after reset release.
  assign in_ready = enable & run_q & ~pend_valid_q;
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    code_d       = code_q;
    cnt_load     = 1'b0;
    cnt_val      = HOLD_LD;
    decide       = 1'b0;
    bypass       = 1'b0;

    case (state_q)
      ST_IDLE: decide = 1'b1;
      ST_DRIVE: begin
        if (cnt_done) begin
          if (HAS_GAP) begin
            state_d  = ST_GAP;
            cnt_load = 1'b1;
            cnt_val  = GAP_LD;
          end else begin
            decide = 1'b1;
          end
        end
      end
      ST_GAP:  decide = cnt_done;
      default: state_d = ST_IDLE;
    endcase

    // Start decision shared by IDLE and the last DRIVE/GAP cycle.
    if (decide) begin
      state_d = ST_IDLE;
      if (pend_valid_q && enable) begin
        state_d      = ST_DRIVE;
        code_d       = pend_code_q;
        pend_valid_d = 1'b0;
        cnt_load     = 1'b1;
        cnt_val      = HOLD_LD;
      end else if (xfer) begin
        state_d  = ST_DRIVE;
        code_d   = in_code;
        bypass   = 1'b1;
        cnt_load = 1'b1;
        cnt_val  = HOLD_LD;
      end
    end

    if (xfer && !bypass) begin
      pend_valid_d = 1'b1;
      pend_code_d  = in_code;
    end

    decode_d = '0;
    if (state_d == ST_DRIVE) begin
      decode_d[code_d] = 1'b1;
    end
    busy_d = (state_d != ST_IDLE) || pend_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      code_q       <= '0;
      decode_q     <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      code_q       <= code_d;
      decode_q     <= decode_d;
      out_valid_q  <= (state_d == ST_DRIVE);
      busy_q       <= busy_d;
      run_q        <= 1'b1;
    end
  end

  hold_counter u_hold_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  assign decode    = decode_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_onehot_decoder.sv
// ============================================================================
// Module      : tb_onehot_decoder
// Description : Self-checking bench: cycle tables for directed sequences,
//               reset mid-drive, and a random stream against a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_decoder;

  localparam int HOLD_A = 2;
  localparam int GAP_A  = 1;

  logic       clk;
  logic       rst_n;
  logic       a_en, a_vld, a_rdy, a_ov, a_busy;
  logic [2:0] a_code;
  logic [7:0] a_dec;
  logic       b_en, b_vld, b_rdy, b_ov, b_busy;
  logic [2:0] b_code;
  logic [7:0] b_dec;

  int errors = 0;
  int checks = 0;

  onehot_decoder #(.N(3), .HOLD(HOLD_A), .GAP(GAP_A)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(a_en), .in_valid(a_vld), .in_code(a_code),
    .in_ready(a_rdy), .decode(a_dec), .out_valid(a_ov), .busy(a_busy)
  );

  onehot_decoder #(.N(3), .HOLD(2), .GAP(0)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(b_en), .in_valid(b_vld), .in_code(b_code),
    .in_ready(b_rdy), .decode(b_dec), .out_valid(b_ov), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sel;      // 0: DUT A (GAP=1), 1: DUT B (GAP=0)
    bit         en;
    bit         vld;
    logic [2:0] code;
    bit         exp_rdy;  // in_ready before the edge
    logic [7:0] exp_dec;  // decode after the edge
    bit         exp_busy; // busy after the edge
  } vec_t;

  vec_t vt[$];
  logic [2:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    if (!v.sel) begin
      a_en = v.en; a_vld = v.vld; a_code = v.code; b_en = 1'b1; b_vld = 1'b0;
    end else begin
      b_en = v.en; b_vld = v.vld; b_code = v.code; a_en = 1'b1; a_vld = 1'b0;
    end
    #1;
    chk($sformatf("v%0d in_ready", idx), v.sel ? b_rdy : a_rdy, v.exp_rdy);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d decode", idx), v.sel ? b_dec : a_dec, v.exp_dec);
    chk($sformatf("v%0d out_valid", idx), v.sel ? b_ov : a_ov, v.exp_dec != 8'h00);
    chk($sformatf("v%0d busy", idx), v.sel ? b_busy : a_busy, v.exp_busy);
  endtask

  // Stream monitor state for DUT A
  logic [7:0] m_prev = 8'h00;
  int         m_run  = 0;
  int         m_zero = 0;
  bit         m_seen = 1'b0;

  task automatic monitor();
    logic [7:0] e;
    chk("stream out_valid", a_ov, a_dec != 8'h00);
    checks++;
    if ($countones(a_dec) > 1) begin
      errors++;
      $display("FAIL stream onehot: got %0h required at most one bit", a_dec);
    end
    if (a_dec != 8'h00) begin
      if (a_dec != m_prev) begin
        if (m_prev != 8'h00) begin
          chk("stream hold width", m_run, HOLD_A);
          m_zero = 0;
        end
        if (m_seen) begin
          checks++;
          if (m_zero < GAP_A) begin
            errors++;
            $display("FAIL stream gap width: got %0d required >= %0d", m_zero, GAP_A);
          end
        end
        if (sb.size() == 0) begin
          chk("stream unexpected pattern", a_dec, 8'h00);
        end else begin
          e = 8'h01 << sb.pop_front();
          chk("stream order", a_dec, e);
        end
        m_run  = 1;
        m_seen = 1'b1;
      end else begin
        m_run++;
      end
      m_zero = 0;
    end else begin
      if (m_prev != 8'h00) chk("stream hold width", m_run, HOLD_A);
      m_zero++;
    end
    m_prev = a_dec;
  endtask

  initial begin
    int sent;
    rst_n = 1'b0;
    a_en = 1'b1; a_vld = 1'b0; a_code = 3'd0;
    b_en = 1'b1; b_vld = 1'b0; b_code = 3'd0;
    #1;
    chk("reset decode", a_dec, 8'h00);
    chk("reset out_valid", a_ov, 1'b0);
    chk("reset busy", a_busy, 1'b0);
    chk("reset in_ready", a_rdy, 1'b0);
    chk("reset b in_ready", b_rdy, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Single code 6, then codes 1/7 back-to-back (5 offered while full)
    vt.push_back('{0, 1, 1, 3'd6, 1, 8'h40, 1});
    vt.push_back('{0, 1, 0, 3'd6, 1, 8'h40, 1});
    vt.push_back('{0, 1, 0, 3'd6, 1, 8'h00, 1});
    vt.push_back('{0, 1, 0, 3'd6, 1, 8'h00, 0});
    vt.push_back('{0, 1, 1, 3'd1, 1, 8'h02, 1});
    vt.push_back('{0, 1, 1, 3'd7, 1, 8'h02, 1});
    vt.push_back('{0, 1, 1, 3'd5, 0, 8'h00, 1});
    vt.push_back('{0, 1, 0, 3'd5, 0, 8'h80, 1});
    vt.push_back('{0, 1, 0, 3'd5, 1, 8'h80, 1});
    vt.push_back('{0, 1, 0, 3'd5, 1, 8'h00, 1});
    vt.push_back('{0, 1, 0, 3'd5, 1, 8'h00, 0});
    // Enable dropped while code 2 drives with code 0 pending
    vt.push_back('{0, 1, 1, 3'd2, 1, 8'h04, 1});
    vt.push_back('{0, 1, 1, 3'd0, 1, 8'h04, 1});
    vt.push_back('{0, 0, 0, 3'd0, 0, 8'h00, 1});
    vt.push_back('{0, 0, 0, 3'd0, 0, 8'h00, 1});
    vt.push_back('{0, 0, 0, 3'd0, 0, 8'h00, 1});
    vt.push_back('{0, 1, 0, 3'd0, 0, 8'h01, 1});
    vt.push_back('{0, 1, 0, 3'd0, 1, 8'h01, 1});
    vt.push_back('{0, 1, 0, 3'd0, 1, 8'h00, 1});
    vt.push_back('{0, 1, 0, 3'd0, 1, 8'h00, 0});
    // GAP=0 instance: codes 3 then 4 with no zero cycle between
    vt.push_back('{1, 1, 1, 3'd3, 1, 8'h08, 1});
    vt.push_back('{1, 1, 1, 3'd4, 1, 8'h08, 1});
    vt.push_back('{1, 1, 0, 3'd4, 0, 8'h10, 1});
    vt.push_back('{1, 1, 0, 3'd4, 1, 8'h10, 1});
    vt.push_back('{1, 1, 0, 3'd4, 1, 8'h00, 0});
    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Reset mid-DRIVE of code 5 with code 3 pending
    @(negedge clk);
    a_en = 1'b1; a_vld = 1'b1; a_code = 3'd5;
    @(posedge clk); #1;
    chk("rst-seq decode 5", a_dec, 8'h20);
    @(negedge clk);
    a_vld = 1'b1; a_code = 3'd3;
    @(posedge clk); #1;
    a_vld = 1'b0;
    chk("rst-seq still 5", a_dec, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("rst-seq decode", a_dec, 8'h00);
    chk("rst-seq out_valid", a_ov, 1'b0);
    chk("rst-seq busy", a_busy, 1'b0);
    chk("rst-seq in_ready", a_rdy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst-seq quiet decode %0d", i), a_dec, 8'h00);
      chk($sformatf("rst-seq quiet busy %0d", i), a_busy, 1'b0);
    end

    // Random stream of 1000 codes on DUT A
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      @(negedge clk);
      a_en   = ($urandom_range(0, 3) != 0);
      a_vld  = $urandom_range(0, 1) == 1;
      a_code = 3'($urandom_range(0, 7));
      #1;
      if (a_vld && a_rdy) begin
        sb.push_back(a_code);
        sent++;
      end
      @(posedge clk); #1;
      monitor();
    end
    chk("stream codes sent", sent, 1000);
    @(negedge clk);
    a_en = 1'b1; a_vld = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      monitor();
      if (sb.size() == 0 && !a_busy && a_dec == 8'h00) break;
    end
    chk("stream drained", sb.size(), 0);
    chk("stream idle busy", a_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
